set_time_controller: RTL and testbench
======================================

# set_time_controller

Sequencing controller for the set-time datapath of the alarm clock. It turns debounced, synchronous front-panel key levels into the single-cycle load, increment, clear and write strobes that the set-time datapath and the alarm register file consume. It runs two kinds of edit session: setting the current time from the running clock, or editing one of the seven alarm registers. Each session either commits the edited value to its destination or aborts it.

## Interface
- REPEAT_DLY, 500: cycles a held H/M key waits before auto-repeat starts.
- REPEAT_RATE, 100: cycles between auto-repeat pulses.
- TIMEOUT, 30000: idle cycles in EDIT before automatic abort.
- CLK  in  1  system clock, all state on rising edge.
- CLEAR  in  1  asynchronous active-high reset; also the datapath global clear.
- KEY_SET  in  1  start a time-set session (source = current time).
- KEY_ALM  in  1  start an alarm-edit session (source = alarm register ALM_SEL).
- ALM_SEL  in  3  alarm register index 0..6; 7 is invalid.
- KEY_H, KEY_M  in  1  increment hours / minutes.
- KEY_D  in  1  increment day.
- KEY_OF  in  1  toggle alarm on/off (alarm sessions only).
- KEY_OK, KEY_ESC  in  1  commit / abort the session.
- S0  out  1  datapath source select: 1 = current time, 0 = alarm register.
- SEL  out  3  alarm register mux select.
- CLEAR_ST, LD_TIME, LD_DAY, LD_O_F, LD_ID, IH, IM, TOF  out  1  single-cycle datapath strobes.
- EN_ST  out  1  set-time counter enable, high for the whole session.
- WR_CT  out  1  one-cycle write of the edited value into the running clock.
- WE  out  7  one-hot one-cycle alarm register write enable.
- BUSY  out  1  high while a session is active (any state except IDLE).

## Operation
- States: IDLE, CLR, LOAD, EDIT, STORE, ABORT.
- All keys are rising-edge detected against a registered copy of each key.
- IDLE:
  - KEY_SET edge -> latch mode=TIME, S0=1, then go to CLR.
  - KEY_ALM edge with ALM_SEL≤6 -> latch mode=ALARM, S0=0, SEL=ALM_SEL, then go to CLR.
  - KEY_ALM with ALM_SEL=7 is ignored.
  - If both edges arrive together, KEY_SET wins.
  - Other keys are ignored in IDLE.
- S0 and SEL are latched on session entry and held until the session returns to IDLE. Changes to ALM_SEL mid-session are ignored.
- CLR: CLEAR_ST=1 for one cycle, then go to LOAD.
- LOAD, one cycle:
  - Time mode: LD_TIME=1 and LD_DAY=1.
  - Alarm mode: LD_TIME=1 and LD_O_F=1.
  - Then go to EDIT.
- EDIT, at most one action per cycle, in priority order:
  - ESC edge -> ABORT.
  - OK edge -> STORE.
  - D edge -> LD_ID pulse.
  - OF edge (alarm mode only; ignored in time mode) -> TOF pulse.
  - H -> IH pulse.
  - M -> IM pulse.
  - A lower-priority event lost in that cycle is dropped, not queued.
- Auto-repeat, H/M:
  - An edge gives an immediate pulse.
  - While the key is held, a second pulse follows REPEAT_DLY cycles after the edge, then one every REPEAT_RATE cycles.
  - Only the highest-priority held key repeats. Releasing it restarts its repeat counter.
- Timeout counter:
  - Reloads on entry to EDIT and on any key edge.
  - Reaching TIMEOUT idle cycles -> ABORT.
- STORE, one cycle: WR_CT=1 in time mode, or WE[SEL]=1 in alarm mode. Then go to IDLE.
- ABORT, one cycle: CLEAR_ST=1, then go to IDLE.
- EN_ST=1 in CLR, LOAD, EDIT and STORE.

## Timing
- Reset values: state IDLE; every output 0 (S0=0, SEL=0, WE=0, BUSY=0); all counters and key registers 0.
- CLEAR asserted at any time, including mid-session, forces IDLE asynchronously. No WE or WR_CT is issued on the way.
- Latency from key edge, where the edge is the first cycle the key reads 1:
  - Session start: CLEAR_ST is high in cycle +1; LD_* are high in cycle +2; EDIT is entered at +3.
  - EDIT actions: the strobe is high in cycle +1.
  - OK: WE or WR_CT is high in cycle +1; BUSY falls at +2.
- All strobes are exactly one cycle wide and are never asserted outside their states.
- The repeat and timeout counters saturate. A parameter value of 0 is treated as 1.

## Test plan
- Reset mid-EDIT in alarm mode 3: assert CLEAR -> all outputs 0 the same cycle, state IDLE, WE never pulses.
- Time session: KEY_SET edge, two KEY_M edges, KEY_H edge, KEY_OK -> S0=1, then CLEAR_ST, then LD_TIME+LD_DAY, then IM, IM, IH, then WR_CT, BUSY=0.
- Alarm session: ALM_SEL=5, KEY_ALM, KEY_OF, KEY_OK -> SEL=5, S0=0, LD_TIME+LD_O_F, TOF pulse, WE=7'b0100000. KEY_ALM with ALM_SEL=7 -> BUSY stays 0.
- Auto-repeat with REPEAT_DLY=4, REPEAT_RATE=2: hold KEY_H for 10 cycles -> IH at offsets 1, 5, 7, 9.
- Simultaneous KEY_ESC+KEY_OK+KEY_H edges in EDIT -> CLEAR_ST only, no IH, no write, then IDLE. KEY_D+KEY_H together -> LD_ID only.
- TIMEOUT=8: enter EDIT with no keys -> CLEAR_ST pulse after 8 idle cycles, then IDLE. A key at idle cycle 7 reloads the count.

Source files
------------

// File: rtl/set_time_controller.sv
// set_time_controller: turns debounced front-panel key levels into one-cycle
// load/increment/clear/write strobes for time-set and alarm-edit sessions.
module set_time_controller #(
  parameter int REPEAT_DLY  = 500,
  parameter int REPEAT_RATE = 100,
  parameter int TIMEOUT     = 30000
) (
  input  logic       clk_i,
  input  logic       clear_i,
  input  logic       key_set_i,
  input  logic       key_alm_i,
  input  logic [2:0] alm_sel_i,
  input  logic       key_h_i,
  input  logic       key_m_i,
  input  logic       key_d_i,
  input  logic       key_of_i,
  input  logic       key_ok_i,
  input  logic       key_esc_i,
  output logic       s0_o,
  output logic [2:0] sel_o,
  output logic       clear_st_o,
  output logic       ld_time_o,
  output logic       ld_day_o,
  output logic       ld_o_f_o,
  output logic       ld_id_o,
  output logic       ih_o,
  output logic       im_o,
  output logic       tof_o,
  output logic       en_st_o,
  output logic       wr_ct_o,
  output logic [6:0] we_o,
  output logic       busy_o
);
  // state | meaning
  // IDLE  | no session, waiting for a SET or ALM key edge
  // CLR   | clear the set-time datapath
  // LOAD  | load the source value into the datapath
  // EDIT  | edit keys, auto-repeat and idle timeout active
  // STORE | write edited value to running clock or alarm register
  // ABORT | discard the edit and clear the datapath
  typedef enum logic [2:0] {ST_IDLE, ST_CLR, ST_LOAD, ST_EDIT, ST_STORE, ST_ABORT} state_t;
  typedef enum logic [1:0] {REP_NONE, REP_H, REP_M} rep_t;

  localparam int DLY_E  = (REPEAT_DLY  < 1) ? 1 : REPEAT_DLY;
  localparam int RATE_E = (REPEAT_RATE < 1) ? 1 : REPEAT_RATE;
  localparam int TO_E   = (TIMEOUT     < 1) ? 1 : TIMEOUT;
  localparam int RW     = $clog2(((DLY_E > RATE_E) ? DLY_E : RATE_E) + 1);
  localparam int TW     = $clog2(TO_E + 1);
  localparam logic [RW-1:0] DLY_LD  = RW'(DLY_E - 1);
  localparam logic [RW-1:0] RATE_LD = RW'(RATE_E - 1);
  localparam logic [TW-1:0] TO_LD   = TW'(TO_E - 1);

  localparam int K_SET = 0, K_ALM = 1, K_H = 2, K_M = 3, K_D = 4, K_OF = 5, K_OK = 6, K_ESC = 7;
  localparam int S_IH = 0, S_IM = 1, S_ID = 2, S_TOF = 3;

  state_t          state_q, state_d;
  rep_t            rep_q, rep_now;
  logic [7:0]      keys_q, keys_now, edge_w;
  logic            alarm_q, alarm_d, s0_q, s0_d;
  logic [2:0]      sel_q, sel_d;
  logic [RW-1:0]   rpt_cnt_q, rpt_cnt_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [3:0]      stb_q, stb_d;
  logic            rep_fire, h_ev, m_ev;

  assign keys_now = {key_esc_i, key_ok_i, key_of_i, key_d_i, key_m_i, key_h_i, key_alm_i, key_set_i};
  assign edge_w   = keys_now & ~keys_q;

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q   <= ST_IDLE;
      keys_q    <= '0;
      alarm_q   <= 1'b0;
      s0_q      <= 1'b0;
      sel_q     <= '0;
      rep_q     <= REP_NONE;
      rpt_cnt_q <= '0;
      to_cnt_q  <= '0;
      stb_q     <= '0;
    end else begin
      state_q   <= state_d;
      keys_q    <= keys_now;
      alarm_q   <= alarm_d;
      s0_q      <= s0_d;
      sel_q     <= sel_d;
      rep_q     <= rep_now;
      rpt_cnt_q <= rpt_cnt_d;
      to_cnt_q  <= to_cnt_d;
      stb_q     <= stb_d;
    end
  end

  // Only the highest-priority held key repeats; a change of that key restarts the delay.
  always_comb begin
    rep_now = REP_NONE;
    if (key_h_i)      rep_now = REP_H;
    else if (key_m_i) rep_now = REP_M;
  end

  assign rep_fire = (rep_now != REP_NONE) && (rep_now == rep_q) && (rpt_cnt_q == '0);
  assign h_ev     = edge_w[K_H] || (rep_fire && rep_now == REP_H);
  assign m_ev     = edge_w[K_M] || (rep_fire && rep_now == REP_M);

  always_comb begin
    rpt_cnt_d = DLY_LD;
    if (rep_now != REP_NONE && rep_now == rep_q) begin
      if (rpt_cnt_q == '0) rpt_cnt_d = RATE_LD;
      else                 rpt_cnt_d = rpt_cnt_q - RW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    alarm_d  = alarm_q;
    s0_d     = s0_q;
    sel_d    = sel_q;
    to_cnt_d = to_cnt_q;
    stb_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (edge_w[K_SET]) begin
          alarm_d = 1'b0;
          s0_d    = 1'b1;
          sel_d   = '0;
          state_d = ST_CLR;
        end else if (edge_w[K_ALM] && alm_sel_i != 3'd7) begin
          alarm_d = 1'b1;
          s0_d    = 1'b0;
          sel_d   = alm_sel_i;
          state_d = ST_CLR;
        end
      end
      ST_CLR:  state_d = ST_LOAD;
      ST_LOAD: begin
        to_cnt_d = TO_LD;
        state_d  = ST_EDIT;
      end
      ST_EDIT: begin
        if (|edge_w)              to_cnt_d = TO_LD;
        else if (to_cnt_q != '0)  to_cnt_d = to_cnt_q - TW'(1);
        // A repeat pulse is not activity, so an expired timeout beats it.
        if (edge_w[K_ESC])                          state_d = ST_ABORT;
        else if (edge_w[K_OK])                      state_d = ST_STORE;
        else if (edge_w[K_D])                       stb_d[S_ID] = 1'b1;
        else if (edge_w[K_OF] && alarm_q)           stb_d[S_TOF] = 1'b1;
        else if (!(|edge_w) && to_cnt_q == '0)      state_d = ST_ABORT;
        else if (h_ev)                              stb_d[S_IH] = 1'b1;
        else if (m_ev)                              stb_d[S_IM] = 1'b1;
      end
      ST_STORE, ST_ABORT: begin
        state_d = ST_IDLE;
        alarm_d = 1'b0;
        s0_d    = 1'b0;
        sel_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s0_o       = s0_q;
  assign sel_o      = sel_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign en_st_o    = (state_q == ST_CLR) || (state_q == ST_LOAD) ||
                      (state_q == ST_EDIT) || (state_q == ST_STORE);
  assign clear_st_o = (state_q == ST_CLR) || (state_q == ST_ABORT);
  assign ld_time_o  = (state_q == ST_LOAD);
  assign ld_day_o   = (state_q == ST_LOAD) && !alarm_q;
  assign ld_o_f_o   = (state_q == ST_LOAD) && alarm_q;
  assign wr_ct_o    = (state_q == ST_STORE) && !alarm_q;
  assign we_o       = ((state_q == ST_STORE) && alarm_q) ? (7'b000_0001 << sel_q) : 7'b0;
  assign ih_o       = stb_q[S_IH];
  assign im_o       = stb_q[S_IM];
  assign ld_id_o    = stb_q[S_ID];
  assign tof_o      = stb_q[S_TOF];

endmodule

// File: tb/tb_set_time_controller.sv
// Bench for set_time_controller: directed sessions from the test plan plus
// random key traffic, all checked against an event-queue reference model.
module tb_set_time_controller;
  localparam int DLY  = 4;
  localparam int RATE = 2;
  localparam int TO   = 8;

  localparam logic [7:0] K_SET = 8'h01, K_ALM = 8'h02, K_H  = 8'h04, K_M   = 8'h08;
  localparam logic [7:0] K_D   = 8'h10, K_OF  = 8'h20, K_OK = 8'h40, K_ESC = 8'h80;

  typedef struct packed {
    logic       s0;
    logic [2:0] sel;
    logic       clear_st, ld_time, ld_day, ld_o_f, ld_id, ih, im, tof, en_st, wr_ct;
    logic [6:0] we;
    logic       busy;
  } out_t;

  logic       clk, clear;
  logic       key_set, key_alm, key_h, key_m, key_d, key_of, key_ok, key_esc;
  logic [2:0] alm_sel;
  logic       s0, clear_st, ld_time, ld_day, ld_o_f, ld_id, ih, im, tof, en_st, wr_ct, busy;
  logic [2:0] sel;
  logic [6:0] we;

  int n_checks = 0;
  int n_errors = 0;

  set_time_controller #(.REPEAT_DLY(DLY), .REPEAT_RATE(RATE), .TIMEOUT(TO)) dut (
    .clk_i(clk), .clear_i(clear),
    .key_set_i(key_set), .key_alm_i(key_alm), .alm_sel_i(alm_sel),
    .key_h_i(key_h), .key_m_i(key_m), .key_d_i(key_d), .key_of_i(key_of),
    .key_ok_i(key_ok), .key_esc_i(key_esc),
    .s0_o(s0), .sel_o(sel), .clear_st_o(clear_st), .ld_time_o(ld_time),
    .ld_day_o(ld_day), .ld_o_f_o(ld_o_f), .ld_id_o(ld_id), .ih_o(ih), .im_o(im),
    .tof_o(tof), .en_st_o(en_st), .wr_ct_o(wr_ct), .we_o(we), .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic out_t pack_out();
    out_t o;
    o.s0 = s0;          o.sel = sel;        o.clear_st = clear_st; o.ld_time = ld_time;
    o.ld_day = ld_day;  o.ld_o_f = ld_o_f;  o.ld_id = ld_id;       o.ih = ih;
    o.im = im;          o.tof = tof;        o.en_st = en_st;       o.wr_ct = wr_ct;
    o.we = we;          o.busy = busy;
    return o;
  endfunction

  // Reference model: session phases are a queue of scheduled output cycles;
  // editing is a mode with arithmetic hold-age and idle-run counters.
  logic [7:0] m_prev;
  int         m_rep, rep_age, idle_run, mode, after_mode;
  bit         m_alarm;
  logic [2:0] m_sel;
  out_t       sched_q[$];
  out_t       cur_exp, last_out;

  task automatic model_reset();
    m_prev = '0; m_rep = 0; rep_age = 0; idle_run = 0;
    mode = 0; after_mode = 0; m_alarm = 1'b0; m_sel = '0;
    sched_q.delete();
    cur_exp = '0;
  endtask

  function automatic out_t sess_base();
    out_t o;
    o = '0;
    o.s0   = !m_alarm;
    o.sel  = m_alarm ? m_sel : 3'd0;
    o.busy = 1'b1;
    return o;
  endfunction

  task automatic start_sess(input bit alarm, input logic [2:0] s);
    out_t o;
    m_alarm = alarm;
    m_sel   = s;
    o = sess_base(); o.clear_st = 1'b1; o.en_st = 1'b1;
    sched_q.push_back(o);
    o = sess_base(); o.ld_time = 1'b1; o.en_st = 1'b1;
    if (alarm) o.ld_o_f = 1'b1; else o.ld_day = 1'b1;
    sched_q.push_back(o);
    after_mode = 2;
  endtask

  task automatic end_sess(input bit commit);
    out_t o;
    o = sess_base();
    if (commit) begin
      o.en_st = 1'b1;
      if (m_alarm) o.we = 7'b000_0001 << m_sel;
      else         o.wr_ct = 1'b1;
    end else begin
      o.clear_st = 1'b1;
    end
    sched_q.push_back(o);
    after_mode = 0;
  endtask

  task automatic model_step(input logic [7:0] k, input logic [2:0] s);
    logic [7:0] e;
    int rn;
    bit fire, h_ev, m_ev, s_ih, s_im, s_id, s_tof;
    e = k & ~m_prev;
    m_prev = k;
    rn = k[2] ? 1 : (k[3] ? 2 : 0);
    if (rn != m_rep) rep_age = 0; else rep_age++;
    m_rep = rn;
    fire = (rn != 0) && (rep_age >= DLY) && (((rep_age - DLY) % RATE) == 0);
    h_ev = e[2] || (fire && rn == 1);
    m_ev = e[3] || (fire && rn == 2);
    {s_ih, s_im, s_id, s_tof} = 4'b0;
    if (mode == 0) begin
      if (e[0])                   start_sess(1'b0, 3'd0);
      else if (e[1] && s != 3'd7) start_sess(1'b1, s);
    end else if (mode == 2) begin
      if (e != 0) idle_run = 0; else idle_run++;
      if (e[7])                    end_sess(1'b0);
      else if (e[6])               end_sess(1'b1);
      else if (e[4])               s_id = 1'b1;
      else if (e[5] && m_alarm)    s_tof = 1'b1;
      else if (idle_run >= TO)     end_sess(1'b0);
      else if (h_ev)               s_ih = 1'b1;
      else if (m_ev)               s_im = 1'b1;
    end
    if (sched_q.size() > 0) begin
      cur_exp = sched_q.pop_front();
      mode = 1;
    end else begin
      if (mode == 1) begin
        mode = after_mode;
        idle_run = 0;
      end
      if (mode == 2) begin
        cur_exp = sess_base();
        cur_exp.en_st = 1'b1;
        cur_exp.ih = s_ih; cur_exp.im = s_im; cur_exp.ld_id = s_id; cur_exp.tof = s_tof;
      end else begin
        cur_exp = '0;
      end
    end
  endtask

  task automatic set_keys(input logic [7:0] k, input logic [2:0] s);
    {key_esc, key_ok, key_of, key_d, key_m, key_h, key_alm, key_set} = k;
    alm_sel = s;
  endtask

  // One clock: check this cycle's outputs, then drive and model this cycle's keys.
  task automatic cycle(input logic [7:0] k, input logic [2:0] s);
    @(negedge clk);
    last_out = pack_out();
    check_val("out", 32'(last_out), 32'(cur_exp));
    set_keys(k, s);
    model_step(k, s);
  endtask

  task automatic do_clear();
    @(negedge clk);
    last_out = pack_out();
    check_val("out", 32'(last_out), 32'(cur_exp));
    clear = 1'b1;
    set_keys(8'h00, 3'd0);
    #1;
    check_val("clr_async", 32'(pack_out()), 32'd0);
    @(negedge clk);
    check_val("clr_hold", 32'(pack_out()), 32'd0);
    clear = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [7:0] rk;
    logic [2:0] rs;
    int first, ih_mask;
    clear = 1'b1;
    set_keys(8'h00, 3'd0);
    model_reset();
    repeat (2) @(negedge clk);
    check_val("reset", 32'(pack_out()), 32'd0);
    clear = 1'b0;
    cycle(8'h00, 3'd0);

    // Time session: M, M, H, OK
    cycle(K_SET, 3'd0);
    cycle(8'h00, 3'd0);
    check_val("ts_s0", 32'(last_out.s0), 32'd1);
    check_val("ts_clr", 32'(last_out.clear_st), 32'd1);
    cycle(8'h00, 3'd0);
    check_val("ts_ld", 32'({last_out.ld_time, last_out.ld_day, last_out.ld_o_f}), 32'b110);
    cycle(K_M, 3'd0);  cycle(8'h00, 3'd0);
    check_val("ts_im1", 32'(last_out.im), 32'd1);
    cycle(K_M, 3'd0);  cycle(8'h00, 3'd0);
    check_val("ts_im2", 32'(last_out.im), 32'd1);
    cycle(K_H, 3'd0);  cycle(8'h00, 3'd0);
    check_val("ts_ih", 32'(last_out.ih), 32'd1);
    cycle(K_OK, 3'd0); cycle(8'h00, 3'd0);
    check_val("ts_wrct", 32'(last_out.wr_ct), 32'd1);
    cycle(8'h00, 3'd0);
    check_val("ts_busy", 32'(last_out.busy), 32'd0);

    // Alarm session on register 5; ALM_SEL wanders mid-session
    cycle(K_ALM, 3'd5);
    cycle(8'h00, 3'd2);
    check_val("al_sel", 32'({last_out.s0, last_out.sel}), 32'h5);
    cycle(8'h00, 3'd2);
    check_val("al_ld", 32'({last_out.ld_time, last_out.ld_day, last_out.ld_o_f}), 32'b101);
    cycle(K_OF, 3'd2); cycle(8'h00, 3'd2);
    check_val("al_tof", 32'(last_out.tof), 32'd1);
    cycle(K_OK, 3'd2); cycle(8'h00, 3'd2);
    check_val("al_we", 32'(last_out.we), 32'h20);
    cycle(8'h00, 3'd2);
    check_val("al_busy", 32'(last_out.busy), 32'd0);
    cycle(K_ALM, 3'd7); cycle(8'h00, 3'd7);
    check_val("al_sel7", 32'(last_out.busy), 32'd0);
    cycle(8'h00, 3'd7);
    check_val("al_sel7b", 32'(last_out.busy), 32'd0);

    // Auto-repeat: hold H for 10 cycles, OF blip (ignored in time mode) keeps the session alive
    cycle(K_SET, 3'd0); cycle(8'h00, 3'd0); cycle(8'h00, 3'd0);
    cycle(K_H, 3'd0);
    ih_mask = 0;
    for (int i = 1; i <= 10; i++) begin
      rk = (i <= 9) ? K_H : 8'h00;
      if (i == 3) rk = rk | K_OF;
      cycle(rk, 3'd0);
      if (last_out.ih) ih_mask = ih_mask | (1 << i);
    end
    check_val("rpt_offsets", 32'(ih_mask), 32'h2A2);
    cycle(K_ESC, 3'd0);
    repeat (3) cycle(8'h00, 3'd0);

    // Simultaneous ESC+OK+H -> abort only
    cycle(K_SET, 3'd0); cycle(8'h00, 3'd0); cycle(8'h00, 3'd0);
    cycle(K_ESC | K_OK | K_H, 3'd0); cycle(8'h00, 3'd0);
    check_val("sim_abort", 32'({last_out.clear_st, last_out.ih, last_out.wr_ct, last_out.en_st}), 32'b1000);
    cycle(8'h00, 3'd0);
    check_val("sim_idle", 32'(last_out.busy), 32'd0);

    // D+H together -> LD_ID only
    cycle(K_SET, 3'd0); cycle(8'h00, 3'd0); cycle(8'h00, 3'd0);
    cycle(K_D | K_H, 3'd0); cycle(8'h00, 3'd0);
    check_val("dh_ldid", 32'({last_out.ld_id, last_out.ih}), 32'b10);
    cycle(K_OK, 3'd0); cycle(8'h00, 3'd0); cycle(8'h00, 3'd0);

    // Timeout with no keys
    cycle(K_SET, 3'd0); cycle(8'h00, 3'd0); cycle(8'h00, 3'd0);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(8'h00, 3'd0);
      if (last_out.clear_st && first < 0) first = i;
    end
    check_val("to_plain", 32'(first), 32'd8);
    check_val("to_idle", 32'(last_out.busy), 32'd0);

    // Timeout reloaded by a key at idle cycle 7
    cycle(K_SET, 3'd0); cycle(8'h00, 3'd0); cycle(8'h00, 3'd0);
    first = -1;
    for (int i = 0; i < 18; i++) begin
      cycle((i == 7) ? K_M : 8'h00, 3'd0);
      if (last_out.clear_st && first < 0) first = i;
    end
    check_val("to_reload", 32'(first), 32'd16);

    // Reset mid-EDIT in alarm mode 3
    cycle(K_ALM, 3'd3); cycle(8'h00, 3'd3); cycle(8'h00, 3'd3);
    cycle(K_H, 3'd3); cycle(K_H, 3'd3);
    check_val("rst_pre", 32'({last_out.busy, last_out.sel}), 32'hB);
    do_clear();
    cycle(K_OK, 3'd3);
    check_val("rst_we", 32'(last_out.we), 32'd0);
    repeat (2) cycle(8'h00, 3'd0);

    // Random key traffic against the model
    rk = '0;
    rs = '0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_clear();
      for (int b = 0; b < 8; b++) begin
        int p_on, p_off;
        p_on  = (b <= 1) ? 3 : (b == 7) ? 2 : (b == 6) ? 4 : (b <= 3) ? 7 : 5;
        p_off = (b == 2 || b == 3) ? 8 : 40;
        if (!rk[b] && $urandom_range(0, 99) < p_on)  rk[b] = 1'b1;
        else if (rk[b] && $urandom_range(0, 99) < p_off) rk[b] = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) rs = 3'($urandom_range(0, 7));
      cycle(rk, rs);
    end
    repeat (4) cycle(8'h00, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
